// File: rtl/pipeline_mem.sv
// Memory stage of the 5-stage RV64 pipeline.
// Takes the execute-stage bundle and performs at most one data-memory load or
// store over a req/ack bus. It then presents a registered writeback bundle to
// WB with valid/ready flow control.
// Optional build macro: MEM_FORWARD_EN adds the fwd_valid/fwd_reg/fwd_data
// bypass outputs.
module pipeline_mem #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  ready,
  input  logic [DATA_WIDTH-1:0] ex_res,
  input  logic [DATA_WIDTH-1:0] r2_val_mem,
  input  logic [4:0]            mem_dst_reg,
  input  logic [31:0]           mem_opcode,
  input  logic [2:0]            mem_operation_size,
  input  logic                  ecall_mem,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [7:0]            dmem_wstrb,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic                  wb_we,
  output logic [4:0]            wb_dst_reg,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_ecall,
  output logic                  wb_misaligned
`ifdef MEM_FORWARD_EN
  ,
  output logic                  fwd_valid,
  output logic [4:0]            fwd_reg,
  output logic [DATA_WIDTH-1:0] fwd_data
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  state_t state, state_next;

  logic                  accept;
  logic                  is_load, is_store, is_mem;
  logic [2:0]            byte_off;
  logic [2:0]            align_mask;
  logic [7:0]            lane_mask;
  logic                  misaligned;

  // Bundle fields kept while the memory access is outstanding.
  logic [DATA_WIDTH-1:0] cap_res;
  logic [4:0]            cap_dst;
  logic [2:0]            cap_size;
  logic [2:0]            cap_off;
  logic                  cap_load;
  logic                  cap_ecall;

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_value;

  assign ready  = (state == IDLE) && (!wb_valid || wb_ready);
  assign accept = in_valid && ready;

  // Decode the incoming bundle: op type, byte lanes and alignment.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    is_load    = (mem_opcode == 32'd1);
    is_store   = (mem_opcode == 32'd2);
    is_mem     = (is_load || is_store) && !ecall_mem;
    byte_off   = ex_res[2:0];
    lane_mask  = 8'h01;
    align_mask = 3'b000;
    unique case (mem_operation_size[1:0])
      2'd0: begin lane_mask = 8'h01; align_mask = 3'b000; end
      2'd1: begin lane_mask = 8'h03; align_mask = 3'b001; end
      2'd2: begin lane_mask = 8'h0F; align_mask = 3'b011; end
      2'd3: begin lane_mask = 8'hFF; align_mask = 3'b111; end
    endcase
    misaligned = is_mem && ((byte_off & align_mask) != 3'b000);
  end

  // Extract the addressed lanes from the read doubleword and extend them.
  always_comb begin
    shifted    = dmem_rdata >> {cap_off, 3'b000};
    load_value = shifted;
    unique case (cap_size[1:0])
      2'd0: load_value = cap_size[2] ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                     : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      2'd1: load_value = cap_size[2] ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                     : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      2'd2: load_value = cap_size[2] ? {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]}
                                     : {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
      2'd3: load_value = shifted;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: only aligned memory ops leave IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept && is_mem && !misaligned) state_next = ACCESS;
      ACCESS:  if (dmem_ack)                        state_next = HOLD;
      HOLD:    if (wb_ready)                        state_next = IDLE;
      default:                                      state_next = IDLE;
    endcase
  end

  // Capture the bundle fields needed to finish a memory access.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; these are always written on acceptance before they are read.
    if (accept) begin
      cap_res   <= ex_res;
      cap_dst   <= mem_dst_reg;
      cap_size  <= mem_operation_size;
      cap_off   <= byte_off;
      cap_load  <= is_load;
      cap_ecall <= ecall_mem;
    end
  end

  // Memory request and writeback bundle registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_wstrb    <= '0;
      wb_valid      <= 1'b0;
      wb_we         <= 1'b0;
      wb_dst_reg    <= '0;
      wb_data       <= '0;
      wb_ecall      <= 1'b0;
      wb_misaligned <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (is_mem && !misaligned) begin
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= {ex_res[ADDR_WIDTH-1:3], 3'b000};
              dmem_wdata <= is_store ? (r2_val_mem << {byte_off, 3'b000}) : '0;
              dmem_wstrb <= is_store ? (lane_mask << byte_off) : 8'h00;
              wb_valid   <= 1'b0;
            end else begin
              wb_valid      <= 1'b1;
              wb_we         <= !misaligned && (mem_dst_reg != 5'd0);
              wb_dst_reg    <= mem_dst_reg;
              wb_data       <= ex_res;
              wb_ecall      <= ecall_mem;
              wb_misaligned <= misaligned;
            end
          end else if (wb_valid && wb_ready) begin
            wb_valid <= 1'b0;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            dmem_req      <= 1'b0;
            wb_valid      <= 1'b1;
            wb_we         <= cap_load && (cap_dst != 5'd0);
            wb_dst_reg    <= cap_dst;
            wb_data       <= cap_load ? load_value : cap_res;
            wb_ecall      <= cap_ecall;
            wb_misaligned <= 1'b0;
          end
        end
        HOLD: begin
          if (wb_ready) wb_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_FORWARD_EN
  // Bypass view of the writeback register for EX/ID forwarding.
  assign fwd_valid = wb_valid && wb_we;
  assign fwd_reg   = wb_dst_reg;
  assign fwd_data  = wb_data;
`endif

endmodule

// File: tb/tb_pipeline_mem.sv
// Self-checking bench for pipeline_mem: directed bundles, expected writeback
// bundles queued at issue and compared by an independent monitor.
module tb_pipeline_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        ready;
  logic [63:0] ex_res;
  logic [63:0] r2_val_mem;
  logic [4:0]  mem_dst_reg;
  logic [31:0] mem_opcode;
  logic [2:0]  mem_operation_size;
  logic        ecall_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_dst_reg;
  logic [63:0] wb_data;
  logic        wb_ecall;
  logic        wb_misaligned;

  typedef struct {
    logic        we;
    logic [4:0]  dst;
    logic [63:0] data;
    logic        ecall;
    logic        mis;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;

  pipeline_mem dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ready(ready),
    .ex_res(ex_res), .r2_val_mem(r2_val_mem), .mem_dst_reg(mem_dst_reg),
    .mem_opcode(mem_opcode), .mem_operation_size(mem_operation_size),
    .ecall_mem(ecall_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_we(wb_we), .wb_dst_reg(wb_dst_reg),
    .wb_data(wb_data), .wb_ecall(wb_ecall), .wb_misaligned(wb_misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_wb(input logic we, input logic [4:0] dst, input logic [63:0] data,
                           input logic ecall, input logic mis);
    wb_exp_t e;
    e.we = we; e.dst = dst; e.data = data; e.ecall = ecall; e.mis = mis;
    exp_q.push_back(e);
  endtask

  // Present a bundle and hold it until the accepting edge has passed.
  task automatic send(input logic [63:0] res, input logic [63:0] r2, input logic [4:0] dst,
                      input logic [31:0] op, input logic [2:0] sz, input logic ecall);
    int t;
    t = 0;
    in_valid = 1'b1; ex_res = res; r2_val_mem = r2; mem_dst_reg = dst;
    mem_opcode = op; mem_operation_size = sz; ecall_mem = ecall;
    while (!ready && t < 50) begin
      step(1);
      t++;
    end
    if (!ready) check("send_ready_timeout", 64'd0, 64'd1);
    step(1);
    in_valid = 1'b0;
  endtask

  // Aligned memory access: check the request, wait, then acknowledge.
  task automatic mem_access(input string name, input logic [63:0] res, input logic [63:0] r2,
                            input logic [4:0] dst, input logic [31:0] op, input logic [2:0] sz,
                            input logic [63:0] rdata, input int waits,
                            input logic [63:0] e_addr, input logic e_we,
                            input logic [63:0] e_wdata, input logic [7:0] e_wstrb);
    send(res, r2, dst, op, sz, 1'b0);
    check({name, "_req"},   {63'd0, dmem_req}, 64'd1);
    check({name, "_addr"},  dmem_addr, e_addr);
    check({name, "_we"},    {63'd0, dmem_we}, {63'd0, e_we});
    check({name, "_wstrb"}, {56'd0, dmem_wstrb}, {56'd0, e_wstrb});
    if (e_we) check({name, "_wdata"}, dmem_wdata, e_wdata);
    for (int i = 0; i < waits; i++) begin
      step(1);
      check({name, "_req_held"},  {63'd0, dmem_req}, 64'd1);
      check({name, "_addr_held"}, dmem_addr, e_addr);
    end
    dmem_ack = 1'b1; dmem_rdata = rdata;
    step(1);
    dmem_ack = 1'b0; dmem_rdata = '0;
    check({name, "_req_drop"}, {63'd0, dmem_req}, 64'd0);
    check({name, "_wb_valid"}, {63'd0, wb_valid}, 64'd1);
  endtask

  // Monitor: compare each handed-off writeback bundle against the queue.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && wb_valid && wb_ready) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wb_we",    {63'd0, wb_we}, {63'd0, e.we});
          check("wb_dst",   {59'd0, wb_dst_reg}, {59'd0, e.dst});
          check("wb_data",  wb_data, e.data);
          check("wb_ecall", {63'd0, wb_ecall}, {63'd0, e.ecall});
          check("wb_mis",   {63'd0, wb_misaligned}, {63'd0, e.mis});
        end
      end
    end
  end

  initial begin
    int t;
    reset = 1'b1; in_valid = 1'b0; ex_res = '0; r2_val_mem = '0; mem_dst_reg = '0;
    mem_opcode = '0; mem_operation_size = '0; ecall_mem = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0; wb_ready = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);

    // Reset state.
    check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
    check("rst_ready",    {63'd0, ready}, 64'd1);
    check("rst_wb_data",  wb_data, 64'd0);
    check("rst_addr",     dmem_addr, 64'd0);

    // ALU bundles back to back, including dst=0 and an ecall marker.
    expect_wb(1'b1, 5'd5, 64'h1234, 1'b0, 1'b0);
    send(64'h1234, 64'd0, 5'd5, 32'd0, 3'd3, 1'b0);
    check("alu_wb_valid", {63'd0, wb_valid}, 64'd1);
    check("alu_ready",    {63'd0, ready}, 64'd1);
    expect_wb(1'b0, 5'd0, 64'hDEAD, 1'b0, 1'b0);
    send(64'hDEAD, 64'd0, 5'd0, 32'd7, 3'd0, 1'b0);
    expect_wb(1'b0, 5'd0, 64'h0, 1'b1, 1'b0);
    send(64'h0, 64'd0, 5'd0, 32'd1, 3'd3, 1'b1);
    check("ecall_no_req", {63'd0, dmem_req}, 64'd0);
    step(2);

    // Signed byte load at 0x1003.
    expect_wb(1'b1, 5'd10, 64'hFFFFFFFFFFFFFF80, 1'b0, 1'b0);
    mem_access("lb", 64'h1003, 64'd0, 5'd10, 32'd1, 3'b000, 64'h00000000_80000000, 0,
               64'h1000, 1'b0, 64'd0, 8'h00);
    step(2);

    // Halfword store of 0xBEEF at 0x2006, three wait cycles.
    expect_wb(1'b0, 5'd7, 64'h2006, 1'b0, 1'b0);
    mem_access("sh", 64'h2006, 64'hBEEF, 5'd7, 32'd2, 3'b001, 64'd0, 3,
               64'h2000, 1'b1, 64'hBEEF000000000000, 8'hC0);
    step(2);

    // Unsigned halfword and signed word loads.
    expect_wb(1'b1, 5'd3, 64'h8001, 1'b0, 1'b0);
    mem_access("lhu", 64'h5002, 64'd0, 5'd3, 32'd1, 3'b101, 64'h00000000_80010000, 1,
               64'h5000, 1'b0, 64'd0, 8'h00);
    expect_wb(1'b1, 5'd4, 64'hFFFFFFFF80000001, 1'b0, 1'b0);
    mem_access("lw", 64'h5004, 64'd0, 5'd4, 32'd1, 3'b010, 64'h80000001_00000000, 0,
               64'h5000, 1'b0, 64'd0, 8'h00);
    step(2);

    // Misaligned word load at 0x3002.
    expect_wb(1'b0, 5'd9, 64'h3002, 1'b0, 1'b1);
    send(64'h3002, 64'd0, 5'd9, 32'd1, 3'b010, 1'b0);
    check("mis_no_req",   {63'd0, dmem_req}, 64'd0);
    check("mis_wb_valid", {63'd0, wb_valid}, 64'd1);
    step(1);
    check("mis_no_req2",  {63'd0, dmem_req}, 64'd0);
    step(2);

    // Doubleword load held by WB back-pressure for four cycles.
    wb_ready = 1'b0;
    expect_wb(1'b1, 5'd12, 64'h1122334455667788, 1'b0, 1'b0);
    mem_access("ld", 64'h4000, 64'd0, 5'd12, 32'd1, 3'b011, 64'h1122334455667788, 0,
               64'h4000, 1'b0, 64'd0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      check("bp_ready",    {63'd0, ready}, 64'd0);
      check("bp_wb_valid", {63'd0, wb_valid}, 64'd1);
      check("bp_wb_data",  wb_data, 64'h1122334455667788);
      step(1);
    end
    wb_ready = 1'b1;
    step(1);
    check("bp_ready_after", {63'd0, ready}, 64'd1);
    check("bp_valid_after", {63'd0, wb_valid}, 64'd0);
    step(2);

    // Reset during ACCESS, then a stray acknowledge.
    send(64'h6000, 64'd0, 5'd8, 32'd1, 3'b011, 1'b0);
    check("racc_req", {63'd0, dmem_req}, 64'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("racc_req_clr",   {63'd0, dmem_req}, 64'd0);
    check("racc_valid_clr", {63'd0, wb_valid}, 64'd0);
    check("racc_ready",     {63'd0, ready}, 64'd1);
    dmem_ack = 1'b1; dmem_rdata = 64'hFFFF;
    step(1);
    dmem_ack = 1'b0;
    check("stray_ack_req",   {63'd0, dmem_req}, 64'd0);
    check("stray_ack_valid", {63'd0, wb_valid}, 64'd0);
    step(2);
    check("stray_ack_valid2", {63'd0, wb_valid}, 64'd0);

    // Drain the scoreboard.
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      step(1);
      t++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
